window_generator: RTL and testbench
===================================

Name: window_generator

Overview:
Streaming 3x3 sliding-window generator that feeds the convolution MAC's data window input.
- Accepts a raster-order stream of signed int8 activation pixels with a valid/ready handshake.
- Buffers KERNEL_SIZE-1 previous image rows in line buffers.
- Emits one complete KERNEL_SIZE x KERNEL_SIZE window per valid output position. Convolution is "valid" style: no padding, stride 1.
- Sits between the activation fetch path and the mac array.

Parameters:
WIDTH, 8, pixel bit width (signed)
KERNEL_SIZE, 3, window edge length
MAX_IMG_WIDTH, 64, line buffer depth (maximum image width)
DIM_BITS, 7, width of the img_width/img_height config ports and internal counters

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches config and begins a frame (honoured only in IDLE)
img_width  in  DIM_BITS  columns per row
img_height  in  DIM_BITS  rows per frame
in_pixel  in  WIDTH  signed input pixel, raster order
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
window  out  WIDTH x KERNEL_SIZE*KERNEL_SIZE  signed unpacked array [0:K*K-1]; index r*K+c; r=0 is the oldest row, c=0 is the leftmost column
win_valid  out  1  window holds a valid window
win_ready  in  1  consumer takes the window
win_last  out  1  qualifies the final window of the frame
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse after the last window handshake
cfg_err  out  1  one-cycle pulse when start carries an illegal config

Behaviour:
Reset values:
- State IDLE.
- in_ready, win_valid, win_last, busy, done, cfg_err = 0.
- window = all zeros; row/col counters = 0.
- Line buffer RAM is not reset; stale contents are never emitted.

States:
- IDLE: on start, the config is legal if K <= img_width <= MAX_IMG_WIDTH and img_height >= K.
  - Legal: latch config, go to RUN.
  - Illegal: pulse cfg_err the next cycle, stay in IDLE.
  - start is ignored in all other states.
- RUN:
  - in_ready = !win_valid || win_ready (single output register stage).
  - A pixel is accepted when in_valid && in_ready.
- DRAIN: entered after the last pixel is accepted. in_ready = 0. Waits for the final window handshake.
- After the final window handshake: pulse done, return to IDLE.

Pixel accept at column col:
- Column vector, top to bottom: lb[0][col], lb[1][col], in_pixel.
- Window registers shift left by one column; the new vector enters column K-1.
- Line buffers update: lb[0][col] <= lb[1][col]; lb[1][col] <= in_pixel.
- col increments and wraps to 0 at img_width-1; row increments on wrap.

Window emission:
- A window is produced when row >= K-1 and col >= K-1 at accept time.
- win_valid rises the cycle after the bottom-right pixel of that window is accepted (latency 1).
- win_valid holds, and window/win_last stay stable, until win_valid && win_ready.
- A new window may load in the same cycle the previous one is handshaken.

Row boundaries and frame size:
- Windows straddling a row boundary (col < K-1) are never emitted.
- Windows per frame = (H-K+1)*(W-K+1).

win_last:
- Set with the window formed by pixel (H-1, W-1).

Backpressure:
- in_ready drops while win_valid && !win_ready. No pixel or window is lost or duplicated.

Reset mid-frame:
- Returns to IDLE with all outputs at reset values.
- The next frame requires a fresh start.

Test Plan:
1. 4x4 frame, pixel = r*4+c, win_ready=1 -> exactly 4 windows. First window {0,1,2,4,5,6,8,9,10}; last window {5,6,7,9,10,11,13,14,15} with win_last=1. done pulses one cycle after the last handshake; busy then drops.
2. Same frame, win_ready held low 5 cycles when the first window appears -> in_ready=0 and window stable across all 5 cycles. Full window sequence identical to test 1.
3. start with img_width=2 (and separately img_width=65, img_height=2) -> cfg_err single-cycle pulse; busy stays 0; subsequent legal start works.
4. 64x3 frame with signed pixels including -128 and 127 -> 62 windows; -128 appears bit-exact in the window; win_last on the 62nd.
5. Assert reset after 6 pixels of a 5x5 frame -> next cycle all outputs are 0 and state is IDLE. A new 5x5 frame with start yields 9 correct windows.
6. Two back-to-back 3x3 frames, start issued in the cycle after done, with in_valid toggled randomly -> one window per frame, each correct, each with win_last=1.

Source files
------------

// File: rtl/window_generator.sv
// Streaming KxK sliding-window generator: buffers K-1 image rows and emits one
// window per valid ("no padding", stride 1) output position behind a single output register.
module window_generator #(
  parameter int WIDTH         = 8,
  parameter int KERNEL_SIZE   = 3,
  parameter int MAX_IMG_WIDTH = 64,
  parameter int DIM_BITS      = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DIM_BITS-1:0]        img_width,
  input  logic [DIM_BITS-1:0]        img_height,
  input  logic signed [WIDTH-1:0]    in_pixel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [WIDTH-1:0]    window [0:KERNEL_SIZE*KERNEL_SIZE-1],
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       win_last,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int ADDR_BITS = $clog2(MAX_IMG_WIDTH);
  localparam int NUM_TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [DIM_BITS-1:0] K_DIM = DIM_BITS'(KERNEL_SIZE);
  localparam logic [DIM_BITS-1:0] K_M1  = DIM_BITS'(KERNEL_SIZE - 1);
  localparam logic [DIM_BITS-1:0] MAX_W = DIM_BITS'(MAX_IMG_WIDTH);
  localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [DIM_BITS-1:0]     last_col;
  logic [DIM_BITS-1:0]     last_row;
  logic [DIM_BITS-1:0]     row;
  logic [DIM_BITS-1:0]     col;
  logic [ADDR_BITS-1:0]    col_addr;
  logic signed [WIDTH-1:0] lb [0:KERNEL_SIZE-2][0:MAX_IMG_WIDTH-1];
  logic signed [WIDTH-1:0] col_vec [0:KERNEL_SIZE-1];
  logic                    accept;
  logic                    out_hs;
  logic                    emit;
  logic                    last_px;
  logic                    cfg_ok;

  assign col_addr = col[ADDR_BITS-1:0];
  assign in_ready = (state == RUN) && (!win_valid || win_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = win_valid && win_ready;
  assign emit     = (row >= K_M1) && (col >= K_M1);
  assign last_px  = (row == last_row) && (col == last_col);
  assign cfg_ok   = (img_width >= K_DIM) && (img_width <= MAX_W) && (img_height >= K_DIM);

  // Column entering the window: oldest buffered row on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE - 1; r++) col_vec[r] = lb[r][col_addr];
    col_vec[KERNEL_SIZE-1] = in_pixel;
  end

  // NOTE: line-buffer RAM has no reset; emission is gated until every row it feeds was rewritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_SIZE - 2; r++) lb[r][col_addr] <= lb[r+1][col_addr];
      lb[KERNEL_SIZE-2][col_addr] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_col  <= '0;
      last_row  <= '0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) window[i] <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              last_col <= img_width - ONE;
              last_row <= img_height - ONE;
              row      <= '0;
              col      <= '0;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // NOTE: non-blocking assignments let every tap read its right neighbour's old value.
            for (int r = 0; r < KERNEL_SIZE; r++) begin
              for (int c = 0; c < KERNEL_SIZE - 1; c++)
                window[r*KERNEL_SIZE+c] <= window[r*KERNEL_SIZE+c+1];
              window[r*KERNEL_SIZE+KERNEL_SIZE-1] <= col_vec[r];
            end
            win_valid <= emit;
            win_last  <= emit && last_px;
            if (last_px) begin
              row   <= '0;
              col   <= '0;
              state <= DRAIN;
            end else if (col == last_col) begin
              col <= '0;
              row <= row + ONE;
            end else begin
              col <= col + ONE;
            end
          end else if (out_hs) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
          end
        end
        DRAIN: begin
          // The only window left is the frame's last one.
          if (out_hs) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator: windows are predicted straight from the
// image array and compared on every output handshake.
module tb_window_generator;

  localparam int K = 3;

  typedef struct packed {
    logic [71:0] px;
    logic        last;
  } win_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [6:0]        img_width;
  logic [6:0]        img_height;
  logic signed [7:0] in_pixel;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] window [0:8];
  logic              win_valid;
  logic              win_ready;
  logic              win_last;
  logic              busy;
  logic              done;
  logic              cfg_err;

  window_generator dut (
    .clk(clk), .reset(reset), .start(start), .img_width(img_width),
    .img_height(img_height), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready), .window(window), .win_valid(win_valid),
    .win_ready(win_ready), .win_last(win_last), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  int stall_cycles = 0;
  int cur_w = 1;
  bit stall_req = 0;
  logic signed [7:0] img [0:7][0:63];
  win_t exp_q[$];
  logic [71:0] got_q[$];
  int lit [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_lit(input string name, input logic [71:0] v, input int l [9]);
    for (int i = 0; i < 9; i++) check(name, int'($signed(v[i*8 +: 8])), l[i]);
  endtask

  // Expected windows in emission order, taken directly from the image rows/columns.
  task automatic build_expected(input int w, input int h);
    win_t e;
    exp_q.delete();
    for (int r = K - 1; r < h; r++)
      for (int c = K - 1; c < w; c++) begin
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.px[(i*K+j)*8 +: 8] = img[r-K+1+i][c-K+1+j];
        e.last = (r == h - 1) && (c == w - 1);
        exp_q.push_back(e);
      end
  endtask

  // Single compare process: every handshake, stall stability, in_ready and done width.
  logic [71:0] prev_px;
  bit stalled_prev = 0;
  bit done_prev = 0;
  int n_hs = 0;
  always @(negedge clk) begin
    logic [71:0] cur;
    win_t e;
    for (int i = 0; i < 9; i++) cur[i*8 +: 8] = window[i];
    if (reset) begin
      stalled_prev = 0;
      done_prev = 0;
    end else begin
      if (win_valid && win_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          check("unexpected window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 9; i++)
            check($sformatf("window %0d tap %0d", n_hs, i), int'(window[i]),
                  int'($signed(e.px[i*8 +: 8])));
          check($sformatf("window %0d win_last", n_hs), int'(win_last), int'(e.last));
        end
        got_q.push_back(cur);
        if (win_last) last_hs_cyc = cyc;
      end
      if (stalled_prev) begin
        check("stalled win_valid held", int'(win_valid), 1);
        for (int i = 0; i < 9; i++)
          check("stalled window stable", int'(window[i]), int'($signed(prev_px[i*8 +: 8])));
      end
      if (win_valid && !win_ready) begin
        stall_cycles++;
        check("in_ready under backpressure", int'(in_ready), 0);
      end
      if (!busy) begin
        check("in_ready while idle", int'(in_ready), 0);
        check("win_valid while idle", int'(win_valid), 0);
      end
      if (done_prev) check("done single cycle", int'(done), 0);
      stalled_prev = win_valid && !win_ready;
      done_prev = done;
      prev_px = cur;
    end
  end

  // Consumer: always ready, except one 5-cycle stall on the first window when requested.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && win_valid) begin
        stall_req = 0;
        win_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    end
  end

  task automatic do_start(input int w, input int h);
    @(posedge clk);
    #1;
    img_width = 7'(w);
    img_height = 7'(h);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit rnd);
    int p = 0;
    bit acc;
    for (int k = 0; k < 20000 && p < n; k++) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel = img[p / cur_w][p % cur_w];
      @(negedge clk);
      if (k == 0) check("busy after start", int'(busy), 1);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) p++;
    end
    in_valid = 1'b0;
    check("pixels accepted", p, n);
  endtask

  task automatic run_frame(input int w, input int h, input bit rnd);
    bit seen = 0;
    cur_w = w;
    build_expected(w, h);
    got_q.delete();
    do_start(w, h);
    drive_pixels(w * h, rnd);
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done seen", int'(seen), 1);
    if (seen) begin
      check("done one cycle after last handshake", cyc, last_hs_cyc + 1);
      check("busy low with done", int'(busy), 0);
    end
    check("window count", got_q.size(), (h - K + 1) * (w - K + 1));
    check("expected windows left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, int'(in_ready), 0);
    check({tag, " win_valid"}, int'(win_valid), 0);
    check({tag, " win_last"}, int'(win_last), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " cfg_err"}, int'(cfg_err), 0);
    for (int i = 0; i < 9; i++) check({tag, " window"}, int'(window[i]), 0);
  endtask

  task automatic illegal_start(input int w, input int h);
    do_start(w, h);
    @(negedge clk);
    check("cfg_err pulse", int'(cfg_err), 1);
    check("busy on illegal cfg", int'(busy), 0);
    @(negedge clk);
    check("cfg_err cleared", int'(cfg_err), 0);
    check("busy stays low", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    img_width = '0;
    img_height = '0;
    in_pixel = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: 4x4 ramp, consumer always ready.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'(r * 4 + c);
    run_frame(4, 4, 0);
    lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    if (got_q.size() == 4) check_lit("t1 first window", got_q[0], lit);
    lit = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    if (got_q.size() == 4) check_lit("t1 last window", got_q[3], lit);

    // 2: same frame, 5-cycle stall on the first window.
    stall_cycles = 0;
    stall_req = 1;
    run_frame(4, 4, 0);
    check("t2 stall cycles", stall_cycles, 5);
    lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    if (got_q.size() == 4) check_lit("t2 first window", got_q[0], lit);

    // 3: illegal configurations, then a legal frame.
    illegal_start(2, 4);
    illegal_start(65, 2);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'(r * 10 + c);
    run_frame(4, 3, 0);

    // 4: 64x3 signed frame with extreme values.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 64; c++) img[r][c] = 8'(r * 50 + c * 3 - 100);
    img[0][0] = -8'sd128;
    img[2][63] = 8'sd127;
    run_frame(64, 3, 0);
    if (got_q.size() == 62) begin
      check("t4 -128 in first window", int'($signed(got_q[0][7:0])), -128);
      check("t4 127 in last window", int'($signed(got_q[61][71:64])), 127);
    end

    // 5: reset after 6 pixels of a 5x5 frame, then a clean 5x5 frame.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[r][c] = 8'(r * 5 + c - 12);
    exp_q.delete();
    cur_w = 5;
    do_start(5, 5);
    drive_pixels(6, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid-frame reset");
    run_frame(5, 5, 0);

    // 6: two back-to-back 3x3 frames, random in_valid, start the cycle after done.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) img[r][c] = 8'(r * 3 + c + 1);
    run_frame(3, 3, 1);
    lit = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    if (got_q.size() == 1) check_lit("t6 frame A", got_q[0], lit);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) img[r][c] = 8'(-(r * 3 + c) - 10);
    run_frame(3, 3, 1);
    lit = '{-10, -11, -12, -13, -14, -15, -16, -17, -18};
    if (got_q.size() == 1) check_lit("t6 frame B", got_q[0], lit);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
